strand_select_stage: RTL and testbench
======================================

# strand_select_stage

Pipeline stage directly downstream of the per-strand state machines. Each cycle it picks one requesting strand using a round-robin arbiter and returns a same-cycle grant, which lets that strand advance its instruction or vector lane. It then registers the winner's instruction, PC, lane select and strided offset into the decode-stage pipeline register. It also squashes a registered instruction whose strand is flushed and holds its output while the downstream stage stalls.

## Interface
- NUM_STRANDS, 4: number of strand state machines arbitrated; must be a power of two, 2..8.
- STRAND_ID_WIDTH, 2: log2(NUM_STRANDS).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- issue_request_i  in  NUM_STRANDS  per-strand issue request; bit s from strand s.
- flush_i  in  NUM_STRANDS  per-strand flush (branch/rollback).
- stall_i  in  1  downstream cannot accept an instruction this cycle.
- instruction_i  in  32*NUM_STRANDS  strand s occupies bits [32s+31:32s]; same packing for pc_i and strided_offset_i.
- pc_i  in  32*NUM_STRANDS  per-strand PC.
- reg_lane_select_i  in  4*NUM_STRANDS  per-strand vector lane, [4s+3:4s].
- strided_offset_i  in  32*NUM_STRANDS  per-strand strided offset.
- grant_o  out  NUM_STRANDS  one-hot or zero; combinational.
- instruction_valid_o  out  1  pipeline register holds a live instruction.
- instruction_o  out  32  registered instruction.
- pc_o  out  32  registered PC.
- reg_lane_select_o  out  4  registered lane.
- strided_offset_o  out  32  registered offset.
- strand_id_o  out  STRAND_ID_WIDTH  strand that owns the registered instruction.

## Operation
- Effective request: req_eff = issue_request_i & ~flush_i. A flushing strand is never granted, even if it requests.
- Grant, when stall_i=0:
  - Round-robin: first strand with req_eff set, searching upward from (last_grant+1) mod NUM_STRANDS and wrapping.
  - The selected bit of grant_o is driven high.
  - When stall_i=1 or req_eff=0, grant_o=0.
- last_grant register:
  - Updated to the granted strand id on every cycle in which grant_o≠0.
  - Holds otherwise.
  - Reset value NUM_STRANDS-1, so strand 0 wins first.
- Pipeline register capture, on a cycle with a grant:
  - Loads the granted strand's instruction, PC, lane and offset, plus strand_id_o.
  - Sets instruction_valid_o=1.
- No grant and stall_i=0:
  - instruction_valid_o←0.
  - Data fields hold their last value; this is don't-care for consumers.
- stall_i=1: all registered outputs hold.
- Squash: if instruction_valid_o=1 and flush_i[strand_id_o]=1, then instruction_valid_o←0 next cycle. This takes priority over hold under stall; a grant to another strand in the same cycle takes priority over the squash.
- Reset: instruction_valid_o=0, instruction_o=0, pc_o=0, reg_lane_select_o=0, strided_offset_o=0, strand_id_o=0, last_grant=NUM_STRANDS-1. grant_o=0 during reset, regardless of requests.

## Timing
- Request to grant: 0 cycles (combinational). A strand sees its grant in the same cycle it requests and advances on the next edge.
- Grant to instruction_valid_o with data: 1 cycle.
- Throughput: one instruction per cycle. Any single strand requesting continuously is granted every cycle. With k strands requesting continuously, each is granted once every k cycles.
- Stall: grant suppressed in the same cycle; data is not lost, because the ungranted strand keeps requesting.
- Flush: squash is visible 1 cycle after flush_i is asserted.

## Configuration
- STRAND_SELECT_ROUND_ROBIN_EN:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, where the lowest-numbered strand with req_eff set wins; last_grant is not implemented.
  - Grant timing, stall, squash and reset behaviour are identical in both builds.

## Test plan
- Reset, then all four strands request with stall_i=0 → grants 0,1,2,3,0 on consecutive cycles; strand_id_o follows one cycle later with instruction_valid_o=1.
- Only strand 2 requests, with instruction 32'h12345678 and pc 32'h100 → grant_o=4'b0100 the same cycle; next cycle instruction_o=32'h12345678, pc_o=32'h100, strand_id_o=2.
- Strands 1 and 3 request, stall_i=1 for 3 cycles → grant_o=0 throughout and outputs held; on release grant_o=4'b0010 (assuming last_grant=0).
- Strand 1 registered with valid=1, then flush_i=4'b0010 while stall_i=1 → instruction_valid_o=0 next cycle.
- issue_request_i=4'b0001 and flush_i=4'b0001 → grant_o=0 and instruction_valid_o=0 next cycle.
- reset asserted mid-stream with all strands requesting → grant_o=0 and instruction_valid_o=0 next cycle; after deassertion the first grant goes to strand 0. In the fixed-priority build, all requesting → strand 0 granted every cycle.

Source files
------------

// File: rtl/strand_select_stage.sv
// Strand arbiter feeding the decode pipeline register; picks one strand per cycle.
// Define STRAND_SELECT_ROUND_ROBIN_EN for round-robin; otherwise lowest strand wins.
module strand_select_stage #(
  parameter int unsigned NUM_STRANDS     = 4,
  parameter int unsigned STRAND_ID_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_STRANDS-1:0]      issue_request_i,
  input  logic [NUM_STRANDS-1:0]      flush_i,
  input  logic                        stall_i,
  input  logic [32*NUM_STRANDS-1:0]   instruction_i,
  input  logic [32*NUM_STRANDS-1:0]   pc_i,
  input  logic [4*NUM_STRANDS-1:0]    reg_lane_select_i,
  input  logic [32*NUM_STRANDS-1:0]   strided_offset_i,
  output logic [NUM_STRANDS-1:0]      grant_o,
  output logic                        instruction_valid_o,
  output logic [31:0]                 instruction_o,
  output logic [31:0]                 pc_o,
  output logic [3:0]                  reg_lane_select_o,
  output logic [31:0]                 strided_offset_o,
  output logic [STRAND_ID_WIDTH-1:0]  strand_id_o
);

  logic [NUM_STRANDS-1:0]     req_eff;
  logic                       grant_any;
  logic [STRAND_ID_WIDTH-1:0] grant_id;
  logic                       grant_en;

  assign req_eff  = issue_request_i & ~flush_i;
  assign grant_en = grant_any & ~stall_i & ~reset;

`ifdef STRAND_SELECT_ROUND_ROBIN_EN
  logic [STRAND_ID_WIDTH-1:0] last_grant_q, last_grant_d;

  // NUM_STRANDS is a power of two, so the wrap is plain truncation.
  always_comb begin
    logic [STRAND_ID_WIDTH-1:0] idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      idx = last_grant_q + STRAND_ID_WIDTH'(i + 1);
      if (!grant_any && req_eff[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_en) begin
      last_grant_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= STRAND_ID_WIDTH'(NUM_STRANDS - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      if (!grant_any && req_eff[i]) begin
        grant_any = 1'b1;
        grant_id  = STRAND_ID_WIDTH'(i);
      end
    end
  end
`endif

  always_comb begin
    grant_o = '0;
    if (grant_en) begin
      grant_o[grant_id] = 1'b1;
    end
  end

  logic                       valid_q, valid_d;
  logic [31:0]                instr_q, instr_d;
  logic [31:0]                pc_q, pc_d;
  logic [3:0]                 lane_q, lane_d;
  logic [31:0]                offset_q, offset_d;
  logic [STRAND_ID_WIDTH-1:0] sid_q, sid_d;

  // A new grant beats a squash of the old occupant; a squash beats a stall hold.
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    lane_d   = lane_q;
    offset_d = offset_q;
    sid_d    = sid_q;
    if (grant_en) begin
      valid_d  = 1'b1;
      instr_d  = instruction_i[32*grant_id +: 32];
      pc_d     = pc_i[32*grant_id +: 32];
      lane_d   = reg_lane_select_i[4*grant_id +: 4];
      offset_d = strided_offset_i[32*grant_id +: 32];
      sid_d    = grant_id;
    end else if (valid_q && flush_i[sid_q]) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      lane_q   <= '0;
      offset_q <= '0;
      sid_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      lane_q   <= lane_d;
      offset_q <= offset_d;
      sid_q    <= sid_d;
    end
  end

  assign instruction_valid_o = valid_q;
  assign instruction_o       = instr_q;
  assign pc_o                = pc_q;
  assign reg_lane_select_o   = lane_q;
  assign strided_offset_o    = offset_q;
  assign strand_id_o         = sid_q;

endmodule

// File: tb/tb_strand_select_stage.sv
// Directed bench for strand_select_stage; expectations follow the build's arbitration mode.
module tb_strand_select_stage;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    issue_request_i;
  logic [N-1:0]    flush_i;
  logic            stall_i;
  logic [32*N-1:0] instruction_i;
  logic [32*N-1:0] pc_i;
  logic [4*N-1:0]  reg_lane_select_i;
  logic [32*N-1:0] strided_offset_i;
  logic [N-1:0]    grant_o;
  logic            instruction_valid_o;
  logic [31:0]     instruction_o;
  logic [31:0]     pc_o;
  logic [3:0]      reg_lane_select_o;
  logic [31:0]     strided_offset_o;
  logic [W-1:0]    strand_id_o;

  logic [31:0] instr_v [N];
  logic [31:0] pc_v    [N];
  logic [3:0]  lane_v  [N];
  logic [31:0] off_v   [N];

  int checks   = 0;
  int failures = 0;

  strand_select_stage #(
    .NUM_STRANDS    (N),
    .STRAND_ID_WIDTH(W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .issue_request_i    (issue_request_i),
    .flush_i            (flush_i),
    .stall_i            (stall_i),
    .instruction_i      (instruction_i),
    .pc_i               (pc_i),
    .reg_lane_select_i  (reg_lane_select_i),
    .strided_offset_i   (strided_offset_i),
    .grant_o            (grant_o),
    .instruction_valid_o(instruction_valid_o),
    .instruction_o      (instruction_o),
    .pc_o               (pc_o),
    .reg_lane_select_o  (reg_lane_select_o),
    .strided_offset_o   (strided_offset_o),
    .strand_id_o        (strand_id_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pack_data();
    for (int s = 0; s < N; s++) begin
      instruction_i[32*s +: 32]   = instr_v[s];
      pc_i[32*s +: 32]            = pc_v[s];
      reg_lane_select_i[4*s +: 4] = lane_v[s];
      strided_offset_i[32*s +: 32] = off_v[s];
    end
  endtask

  // Advance one edge and let the registers settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input int s);
    check({tag, "_valid"}, 32'(instruction_valid_o), 32'd1);
    check({tag, "_sid"}, 32'(strand_id_o), 32'(s));
    check({tag, "_instr"}, instruction_o, instr_v[s]);
    check({tag, "_pc"}, pc_o, pc_v[s]);
    check({tag, "_lane"}, 32'(reg_lane_select_o), 32'(lane_v[s]));
    check({tag, "_off"}, strided_offset_o, off_v[s]);
  endtask

  int exp_s;

  initial begin
    for (int s = 0; s < N; s++) begin
      instr_v[s] = 32'hA000_0000 + 32'(s);
      pc_v[s]    = 32'h0000_1000 + 32'(4 * s);
      lane_v[s]  = 4'(s + 5);
      off_v[s]   = 32'h0000_0040 * 32'(s + 1);
    end
    pack_data();
    reset = 1'b1;
    issue_request_i = 4'b1111;
    flush_i = '0;
    stall_i = 1'b0;
    #1;
    check("reset_grant", 32'(grant_o), 32'd0);
    tick();
    check("reset_valid", 32'(instruction_valid_o), 32'd0);
    check("reset_instr", instruction_o, 32'd0);
    check("reset_pc", pc_o, 32'd0);
    check("reset_lane", 32'(reg_lane_select_o), 32'd0);
    check("reset_off", strided_offset_o, 32'd0);
    check("reset_sid", 32'(strand_id_o), 32'd0);
    reset = 1'b0;

    // All strands requesting.
    for (int k = 0; k < 5; k++) begin
`ifdef STRAND_SELECT_ROUND_ROBIN_EN
      exp_s = k % N;
`else
      exp_s = 0;
`endif
      #1;
      check("all_grant", 32'(grant_o), 32'(1 << exp_s));
      tick();
      check_reg("all_reg", exp_s);
    end

    // Stall with strands 1 and 3 requesting: no grant, outputs held.
    issue_request_i = 4'b1010;
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_grant", 32'(grant_o), 32'd0);
      tick();
      check_reg("stall_hold", 0);
    end
    stall_i = 1'b0;
    #1;
    check("release_grant", 32'(grant_o), 32'b0010);
    tick();
    check_reg("release_reg", 1);

    // Flush of the registered strand under stall squashes it.
    issue_request_i = '0;
    stall_i = 1'b1;
    flush_i = 4'b0010;
    #1;
    check("squash_grant", 32'(grant_o), 32'd0);
    tick();
    check("squash_valid", 32'(instruction_valid_o), 32'd0);
    check("squash_sid_held", 32'(strand_id_o), 32'd1);
    flush_i = '0;
    stall_i = 1'b0;

    // Single strand 2 with specific payload.
    instr_v[2] = 32'h1234_5678;
    pc_v[2]    = 32'h0000_0100;
    pack_data();
    issue_request_i = 4'b0100;
    #1;
    check("s2_grant", 32'(grant_o), 32'b0100);
    tick();
    check_reg("s2_reg", 2);

    // Requesting strand is also flushing: never granted.
    issue_request_i = 4'b0001;
    flush_i = 4'b0001;
    #1;
    check("reqflush_grant", 32'(grant_o), 32'd0);
    tick();
    check("reqflush_valid", 32'(instruction_valid_o), 32'd0);
    flush_i = '0;

    // New grant wins over squash of the registered strand.
    issue_request_i = 4'b0100;
    #1;
    check("pre_grant", 32'(grant_o), 32'b0100);
    tick();
    issue_request_i = 4'b0010;
    flush_i = 4'b0100;
    #1;
    check("over_squash_grant", 32'(grant_o), 32'b0010);
    tick();
    check_reg("over_squash_reg", 1);
    flush_i = '0;

    // Idle without stall drops valid.
    issue_request_i = '0;
    tick();
    check("idle_valid", 32'(instruction_valid_o), 32'd0);

    // Mid-stream reset.
    issue_request_i = 4'b1111;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midreset_grant", 32'(grant_o), 32'd0);
    tick();
    check("midreset_valid", 32'(instruction_valid_o), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
`ifdef STRAND_SELECT_ROUND_ROBIN_EN
      exp_s = k;
`else
      exp_s = 0;
`endif
      #1;
      check("after_reset_grant", 32'(grant_o), 32'(1 << exp_s));
      tick();
      check("after_reset_sid", 32'(strand_id_o), 32'(exp_s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
